qed_inst_constraint_seq: RTL and testbench
==========================================

Name: qed_inst_constraint_seq

Overview:
- Sequential successor of the SQED instruction-constraint block. Sits at the fetch boundary of the formal SQED harness.
- Classifies each presented RV32IM instruction as legal or illegal, using a parametrised original-register partition and per-class enables.
- Enforces instruction stability across pipeline stalls.
- Enforces a bounded original-instruction budget, followed by a mandatory NOP drain.
- Exports `ok` as the single signal the harness assumes every cycle, plus a `drain_done` trigger for the QED consistency check.

Parameters:
- ORIG_REGS, 16: legal rd/rs1/rs2 must be < ORIG_REGS (lower half of the register file); 1..32.
- ENABLE_MUL, 1: admit MUL/MULH/MULHSU/MULHU.
- ENABLE_MEM, 1: admit LW/SW.
- MAX_ORIG, 8: number of accepted non-NOP instructions before entering DRAIN; >= 1.
- DRAIN_LEN, 6: number of accepted NOPs required in DRAIN before DONE; >= 1.
- CNT_W, 4: counter width; must hold max(MAX_ORIG, DRAIN_LEN).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- instruction, input, 32: instruction presented by fetch.
- inst_valid, input, 1: instruction is presented this cycle.
- stall, input, 1: pipeline is not accepting this cycle.
- legal, output, 1: combinational class and register legality of `instruction`.
- ok, output, 1: combinational; the harness assumes `ok` every cycle.
- orig_count, output, CNT_W: accepted non-NOP instructions so far.
- drain_count, output, CNT_W: accepted NOPs while in DRAIN.
- state, output, 2: 0 RUN, 1 DRAIN, 2 DONE.
- drain_done, output, 1: high in DONE.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=RUN, orig_count=0, drain_count=0, held_valid=0, held_inst=0, drain_done=0. `legal` and `ok` are combinational and are not reset.
- While rst=1, `ok` is forced to 1.
- Field decode uses the standard RV32 positions for funct7, funct3, rd, rs1, rs2 and opcode.
- R-type (opcode 0110011), with rd, rs1, rs2 < ORIG_REGS:
  - ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND, using the standard funct7 values 0000000/0100000.
  - MUL..MULHU (funct7=0000001, funct3 000..011) only if ENABLE_MUL=1.
- I-type (opcode 0010011), with rd, rs1 < ORIG_REGS:
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI: any immediate.
  - SLLI/SRLI require funct7=0000000; SRAI requires funct7=0100000.
- LW (opcode 0000011, funct3 010) and SW (opcode 0100011, funct3 010), only if ENABLE_MEM=1:
  - rs1 must be 0 and instruction[31:30] must be 00.
  - LW requires rd < ORIG_REGS; SW requires rs2 < ORIG_REGS.
- NOP: opcode 1111111, all other bits don't-care. Always legal.
- legal = OR of all enabled classes.
- Handshake: accept = inst_valid && !stall && ok.
- Stall hold:
  - When inst_valid && stall, the next cycle sets held_valid=1 and held_inst=instruction.
  - While held_valid=1, stability requires inst_valid=1 and instruction==held_inst.
  - held_valid clears on the cycle after an accept.
  - A stall whose instruction is not `ok` does not capture held_inst.
- Phase rule:
  - RUN: any legal instruction.
  - DRAIN and DONE: only NOP.
- ok = rst || !inst_valid && !held_valid || (inst_valid && legal && stability && phase rule).
- RUN:
  - An accepted non-NOP increments orig_count.
  - The increment that makes orig_count==MAX_ORIG moves state to DRAIN on the same edge.
  - Accepted NOPs in RUN do not count.
- DRAIN:
  - An accepted NOP increments drain_count.
  - Reaching DRAIN_LEN moves state to DONE; drain_done=1 from the next cycle.
- DONE: sticky until rst; counters frozen; only NOP is ok.
- Cycles with ok=0 (illegal instruction, stability broken, non-NOP in DRAIN) update no state.
- A stall in the same cycle as the budget-reaching instruction means no accept: no count and no transition.
- Counters never wrap; they saturate at their limits by construction of the FSM.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) with inst_valid=1, stall=0 -> legal=1, ok=1; orig_count=1 next cycle.
- ADD x17,x1,x2 (rd=17) with ORIG_REGS=16 -> legal=0, ok=0, orig_count unchanged. Same with MUL when ENABLE_MUL=0 -> legal=0.
- inst_valid=1, stall=1 on XORI 0x0040C093; next cycle present ADDI 0x00108093 -> ok=0. Re-presenting 0x0040C093 -> ok=1; after stall drops, accept and held_valid=0.
- MAX_ORIG=8: eight accepted ADDs -> state=DRAIN after the 8th edge; ADD in DRAIN -> ok=0; NOP 0x0000007F -> ok=1, drain_count=1.
- DRAIN_LEN=6 NOPs accepted -> state=DONE, drain_done=1 next cycle. Further NOPs keep counters at 8/6; a non-NOP gives ok=0.
- Assert rst in DRAIN with orig_count=8 -> next cycle state=RUN, counters 0, drain_done=0, ok=1 during the reset cycle.

Source files
------------

// File: rtl/qed_inst_constraint_seq.sv
// SQED fetch-boundary instruction constraint with stall stability,
// original-instruction budget and mandatory NOP drain phase.
module qed_inst_constraint_seq #(
    parameter int ORIG_REGS  = 16,
    parameter int ENABLE_MUL = 1,
    parameter int ENABLE_MEM = 1,
    parameter int MAX_ORIG   = 8,
    parameter int DRAIN_LEN  = 6,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             inst_valid,
    input  logic             stall,
    output logic             legal,
    output logic             ok,
    output logic [CNT_W-1:0] orig_count,
    output logic [CNT_W-1:0] drain_count,
    output logic [1:0]       state,
    output logic             drain_done
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } phase_t;

    localparam logic [5:0]       REG_LIM    = 6'(ORIG_REGS);
    localparam logic [CNT_W-1:0] ORIG_LAST  = CNT_W'(MAX_ORIG - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_NOP   = 7'b1111111;

    phase_t            state_q, state_d;
    logic [CNT_W-1:0]  orig_d, drain_d;
    logic              held_valid, held_valid_d;
    logic [31:0]       held_inst, held_inst_d;

    logic [6:0] funct7;
    logic [4:0] rs2, rs1, rd;
    logic [2:0] funct3;
    logic [6:0] opcode;
    logic       rd_ok, rs1_ok, rs2_ok;
    logic       r_legal, i_legal, lw_legal, sw_legal, mem_base, is_nop;
    logic       stable, phase_ok, accept;

    assign funct7 = instruction[31:25];
    assign rs2    = instruction[24:20];
    assign rs1    = instruction[19:15];
    assign funct3 = instruction[14:12];
    assign rd     = instruction[11:7];
    assign opcode = instruction[6:0];

    // 6-bit compare so ORIG_REGS=32 admits every register
    assign rd_ok  = {1'b0, rd}  < REG_LIM;
    assign rs1_ok = {1'b0, rs1} < REG_LIM;
    assign rs2_ok = {1'b0, rs2} < REG_LIM;

    // Per-class instruction legality decode
    always_comb begin
        r_legal = 1'b0;
        i_legal = 1'b0;
        if (opcode == OP_R && rd_ok && rs1_ok && rs2_ok) begin
            case (funct7)
                7'b0000000: r_legal = 1'b1;
                7'b0100000: r_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                7'b0000001: r_legal = (ENABLE_MUL != 0) && !funct3[2];
                default:    r_legal = 1'b0;
            endcase
        end
        if (opcode == OP_I && rd_ok && rs1_ok) begin
            case (funct3)
                3'b001:  i_legal = (funct7 == 7'b0000000);
                3'b101:  i_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                default: i_legal = 1'b1;
            endcase
        end
    end

    assign mem_base = (ENABLE_MEM != 0) && (funct3 == 3'b010) && (rs1 == 5'd0)
                      && (instruction[31:30] == 2'b00);
    assign lw_legal = mem_base && (opcode == OP_LOAD)  && rd_ok;
    assign sw_legal = mem_base && (opcode == OP_STORE) && rs2_ok;
    assign is_nop   = (opcode == OP_NOP);
    assign legal    = r_legal || i_legal || lw_legal || sw_legal || is_nop;

    assign stable   = !held_valid || (inst_valid && (instruction == held_inst));
    assign phase_ok = (state_q == RUN) || is_nop;
    assign ok       = rst || (!inst_valid && !held_valid)
                      || (inst_valid && legal && stable && phase_ok);
    assign accept   = inst_valid && !stall && ok;

    assign state       = state_q;
    assign drain_done  = (state_q == DONE);

    // Next-state, counter and stall-hold logic
    always_comb begin
        state_d      = state_q;
        orig_d       = orig_count;
        drain_d      = drain_count;
        held_valid_d = held_valid;
        held_inst_d  = held_inst;

        if (accept) begin
            held_valid_d = 1'b0;
        end else if (inst_valid && stall && ok) begin
            held_valid_d = 1'b1;
            held_inst_d  = instruction;
        end

        case (state_q)
            RUN: begin
                if (accept && !is_nop) begin
                    orig_d = orig_count + 1'b1;
                    if (orig_count == ORIG_LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // phase rule guarantees an accept here is a NOP
                if (accept) begin
                    drain_d = drain_count + 1'b1;
                    if (drain_count == DRAIN_LAST) state_d = DONE;
                end
            end
            default: ;
        endcase
    end

    // State, counters and held instruction register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            orig_count  <= '0;
            drain_count <= '0;
            held_valid  <= 1'b0;
            held_inst   <= '0;
        end else begin
            state_q     <= state_d;
            orig_count  <= orig_d;
            drain_count <= drain_d;
            held_valid  <= held_valid_d;
            held_inst   <= held_inst_d;
        end
    end

endmodule

// File: tb/tb_qed_inst_constraint_seq.sv
// Testbench for qed_inst_constraint_seq: legality vector table, directed
// budget/drain/stall sequences, and randomized traffic against a model.
module tb_qed_inst_constraint_seq;

    localparam int MAX_ORIG  = 8;
    localparam int DRAIN_LEN = 6;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      instruction;
    logic             inst_valid;
    logic             stall;
    logic             legal, ok, drain_done;
    logic [CNT_W-1:0] orig_count, drain_count;
    logic [1:0]       state;

    logic             legal_b, ok_b, drain_done_b;
    logic [CNT_W-1:0] orig_count_b, drain_count_b;
    logic [1:0]       state_b;

    int errors = 0;
    int checks = 0;

    // model state
    int          m_orig, m_drain, m_phase;
    logic        m_hv;
    logic [31:0] m_hi;

    typedef struct {
        logic [31:0] ins;
        logic        l16;
        logic        l32;
        string       nm;
    } vec_t;

    vec_t vecs[23];

    qed_inst_constraint_seq #(
        .ORIG_REGS(16), .ENABLE_MUL(1), .ENABLE_MEM(1),
        .MAX_ORIG(MAX_ORIG), .DRAIN_LEN(DRAIN_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .inst_valid(inst_valid),
        .stall(stall), .legal(legal), .ok(ok), .orig_count(orig_count),
        .drain_count(drain_count), .state(state), .drain_done(drain_done)
    );

    qed_inst_constraint_seq #(
        .ORIG_REGS(32), .ENABLE_MUL(0), .ENABLE_MEM(0),
        .MAX_ORIG(MAX_ORIG), .DRAIN_LEN(DRAIN_LEN), .CNT_W(CNT_W)
    ) dut_b (
        .clk(clk), .rst(rst), .instruction(instruction), .inst_valid(inst_valid),
        .stall(stall), .legal(legal_b), .ok(ok_b), .orig_count(orig_count_b),
        .drain_count(drain_count_b), .state(state_b), .drain_done(drain_done_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rv(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [2:0] f3,
                                       input logic [4:0] d, input logic [6:0] op);
        return {f7, r2, r1, f3, d, op};
    endfunction

    // Mnemonic-level legality rules
    function automatic logic ref_legal(input logic [31:0] i, input int regs,
                                       input bit mul, input bit mem);
        int   d  = int'(i[11:7]);
        int   a  = int'(i[19:15]);
        int   b  = int'(i[24:20]);
        int   f3 = int'(i[14:12]);
        int   f7 = int'(i[31:25]);
        int   op = int'(i[6:0]);
        if (op == 'h7F) return 1'b1;
        if (op == 'h33) begin
            if (d >= regs || a >= regs || b >= regs) return 1'b0;
            if (f7 == 0) return 1'b1;
            if (f7 == 'h20 && (f3 == 0 || f3 == 5)) return 1'b1;
            if (mul && f7 == 1 && f3 <= 3) return 1'b1;
            return 1'b0;
        end
        if (op == 'h13) begin
            if (d >= regs || a >= regs) return 1'b0;
            if (f3 == 1) return f7 == 0;
            if (f3 == 5) return f7 == 0 || f7 == 'h20;
            return 1'b1;
        end
        if (mem && (op == 'h03 || op == 'h23) && f3 == 2 && a == 0 && i[31:30] == 2'b00) begin
            if (op == 'h03) return d < regs;
            return b < regs;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive, compare mid-cycle, advance model, return #1 after the edge
    task automatic step(input logic r, input logic v, input logic s, input logic [31:0] ins);
        logic el, el32, eok, nop, acc;
        rst = r; inst_valid = v; stall = s; instruction = ins;
        el   = ref_legal(ins, 16, 1'b1, 1'b1);
        el32 = ref_legal(ins, 32, 1'b0, 1'b0);
        nop  = (ins[6:0] == 7'h7F);
        eok  = r || (!v && !m_hv) ||
               (v && el && (!m_hv || ins == m_hi) && (m_phase == 0 || nop));
        #4;
        chk("legal", {31'd0, legal}, {31'd0, el});
        chk("legal_b", {31'd0, legal_b}, {31'd0, el32});
        chk("ok", {31'd0, ok}, {31'd0, eok});
        chk("state", {30'd0, state}, m_phase);
        chk("orig_count", {28'd0, orig_count}, m_orig);
        chk("drain_count", {28'd0, drain_count}, m_drain);
        chk("drain_done", {31'd0, drain_done}, {31'd0, m_phase == 2});
        acc = v && !s && eok;
        if (r) begin
            m_orig = 0; m_drain = 0; m_phase = 0; m_hv = 1'b0; m_hi = '0;
        end else if (acc) begin
            m_hv = 1'b0;
            if (m_phase == 0 && !nop) begin
                m_orig++;
                if (m_orig == MAX_ORIG) m_phase = 1;
            end else if (m_phase == 1) begin
                m_drain++;
                if (m_drain == DRAIN_LEN) m_phase = 2;
            end
        end else if (v && s && eok) begin
            m_hv = 1'b1;
            m_hi = ins;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] rnd = $urandom;
        logic [6:0]  f7;
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = rnd[31:25];
        endcase
        case ($urandom_range(0, 5))
            0: return {rnd[31:7], 7'h7F};
            1: return rv(f7, 5'($urandom_range(0, 19)), 5'($urandom_range(0, 19)),
                         rnd[14:12], 5'($urandom_range(0, 19)), 7'h33);
            2: return rv(f7, rnd[24:20], 5'($urandom_range(0, 19)),
                         rnd[14:12], 5'($urandom_range(0, 19)), 7'h13);
            3: return rv(($urandom_range(0, 3) == 0) ? rnd[31:25] : {2'b00, rnd[29:25]},
                         5'($urandom_range(0, 19)),
                         ($urandom_range(0, 3) == 0) ? 5'd1 : 5'd0,
                         ($urandom_range(0, 3) == 0) ? rnd[14:12] : 3'b010,
                         5'($urandom_range(0, 19)),
                         ($urandom_range(0, 1) == 0) ? 7'h03 : 7'h23);
            4: return rnd;
            default: return rv(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33);
        endcase
    endfunction

    localparam logic [31:0] ADD3   = 32'h002081B3;
    localparam logic [31:0] XORI1  = 32'h0040C093;
    localparam logic [31:0] ADDI1  = 32'h00108093;
    localparam logic [31:0] NOP    = 32'h0000007F;

    initial begin
        logic [31:0] ins, add17;
        logic v, s, r;

        add17 = rv(7'h00, 5'd2, 5'd1, 3'b000, 5'd17, 7'h33);
        vecs[0]  = '{ADD3, 1'b1, 1'b1, "add_x3"};
        vecs[1]  = '{add17, 1'b0, 1'b1, "add_rd17"};
        vecs[2]  = '{rv(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 1'b1, 1'b0, "mul"};
        vecs[3]  = '{rv(7'h01, 5'd2, 5'd1, 3'd3, 5'd3, 7'h33), 1'b1, 1'b0, "mulhu"};
        vecs[4]  = '{rv(7'h01, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33), 1'b0, 1'b0, "div"};
        vecs[5]  = '{rv(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 1'b1, 1'b1, "sub"};
        vecs[6]  = '{rv(7'h20, 5'd2, 5'd1, 3'd1, 5'd3, 7'h33), 1'b0, 1'b0, "sll_f7_20"};
        vecs[7]  = '{rv(7'h20, 5'd2, 5'd1, 3'd5, 5'd3, 7'h33), 1'b1, 1'b1, "sra"};
        vecs[8]  = '{XORI1, 1'b1, 1'b1, "xori"};
        vecs[9]  = '{rv(7'h20, 5'd3, 5'd1, 3'd1, 5'd3, 7'h13), 1'b0, 1'b0, "slli_f7_20"};
        vecs[10] = '{rv(7'h20, 5'd3, 5'd1, 3'd5, 5'd3, 7'h13), 1'b1, 1'b1, "srai"};
        vecs[11] = '{rv(7'h01, 5'd3, 5'd1, 3'd5, 5'd3, 7'h13), 1'b0, 1'b0, "srli_f7_01"};
        vecs[12] = '{rv(7'h00, 5'd3, 5'd20, 3'd0, 5'd3, 7'h13), 1'b0, 1'b1, "addi_rs1_20"};
        vecs[13] = '{rv(7'h00, 5'd4, 5'd0, 3'd2, 5'd5, 7'h03), 1'b1, 1'b0, "lw"};
        vecs[14] = '{rv(7'h00, 5'd4, 5'd1, 3'd2, 5'd5, 7'h03), 1'b0, 1'b0, "lw_rs1"};
        vecs[15] = '{rv(7'h20, 5'd4, 5'd0, 3'd2, 5'd5, 7'h03), 1'b0, 1'b0, "lw_hibits"};
        vecs[16] = '{rv(7'h00, 5'd5, 5'd0, 3'd2, 5'd4, 7'h23), 1'b1, 1'b0, "sw"};
        vecs[17] = '{rv(7'h00, 5'd16, 5'd0, 3'd2, 5'd4, 7'h23), 1'b0, 1'b0, "sw_rs2_16"};
        vecs[18] = '{32'hFFFFFFFF, 1'b1, 1'b1, "nop_ones"};
        vecs[19] = '{rv(7'h00, 5'd4, 5'd0, 3'd0, 5'd5, 7'h03), 1'b0, 1'b0, "lb"};
        vecs[20] = '{32'h123450B7, 1'b0, 1'b0, "lui"};
        vecs[21] = '{rv(7'h00, 5'd15, 5'd15, 3'd0, 5'd15, 7'h33), 1'b1, 1'b1, "add_x15"};
        vecs[22] = '{rv(7'h7F, 5'h1F, 5'd2, 3'd3, 5'd4, 7'h13), 1'b1, 1'b1, "sltiu_imm"};

        m_orig = 0; m_drain = 0; m_phase = 0; m_hv = 1'b0; m_hi = '0;
        rst = 1'b1; inst_valid = 1'b0; stall = 1'b0; instruction = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset cycle with an illegal instruction presented: ok forced
        step(1'b1, 1'b1, 1'b0, add17);

        // legality table
        for (int k = 0; k < 23; k++) begin
            instruction = vecs[k].ins;
            inst_valid = 1'b0; stall = 1'b0; rst = 1'b0;
            #4;
            chk({"tbl_", vecs[k].nm}, {31'd0, legal}, {31'd0, vecs[k].l16});
            chk({"tblb_", vecs[k].nm}, {31'd0, legal_b}, {31'd0, vecs[k].l32});
            @(posedge clk);
            #1;
        end

        // basic accept, illegal reject
        step(1'b0, 1'b1, 1'b0, ADD3);
        chk("orig_after_add", {28'd0, orig_count}, 32'd1);
        step(1'b0, 1'b1, 1'b0, add17);
        chk("orig_after_illegal", {28'd0, orig_count}, 32'd1);

        // stall hold and stability
        step(1'b0, 1'b1, 1'b1, XORI1);
        step(1'b0, 1'b1, 1'b0, ADDI1);
        step(1'b0, 1'b1, 1'b1, XORI1);
        step(1'b0, 1'b1, 1'b0, XORI1);
        chk("orig_after_held", {28'd0, orig_count}, 32'd2);
        step(1'b0, 1'b0, 1'b0, ADDI1);

        // budget: stall on the budget-reaching ADD does not count
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, ADD3);
        step(1'b0, 1'b1, 1'b1, ADD3);
        chk("no_trans_on_stall", {30'd0, state}, 32'd0);
        step(1'b0, 1'b1, 1'b0, ADD3);
        chk("drain_entered", {30'd0, state}, 32'd1);
        chk("orig_full", {28'd0, orig_count}, 32'd8);
        step(1'b0, 1'b1, 1'b0, ADD3);
        step(1'b0, 1'b1, 1'b0, NOP);
        chk("drain_one", {28'd0, drain_count}, 32'd1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, NOP);
        chk("done_state", {30'd0, state}, 32'd2);
        chk("done_flag", {31'd0, drain_done}, 32'd1);
        step(1'b0, 1'b1, 1'b0, NOP);
        step(1'b0, 1'b1, 1'b0, ADD3);
        chk("done_orig", {28'd0, orig_count}, 32'd8);
        chk("done_drain", {28'd0, drain_count}, 32'd6);

        // reset in DRAIN
        step(1'b1, 1'b0, 1'b0, NOP);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, ADD3);
        chk("drain_again", {30'd0, state}, 32'd1);
        step(1'b1, 1'b1, 1'b0, ADD3);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_orig", {28'd0, orig_count}, 32'd0);
        chk("rst_done", {31'd0, drain_done}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 2) == 0);
            if (m_hv && $urandom_range(0, 9) < 7) ins = m_hi;
            else if (m_phase != 0 && $urandom_range(0, 1) == 0) ins = {$urandom, 7'h7F} >> 0;
            else ins = rand_inst();
            if (m_phase != 0 && !m_hv && $urandom_range(0, 1) == 0) ins[6:0] = 7'h7F;
            step(r, v, s, ins);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
